// File: rtl/uart_tx_fifo_drain_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain_if
//
// Read-side connection between the 16-byte transmit FIFO and the UART
// transmitter that drains it. The FIFO read port is registered: data appears
// on fifo_data in the cycle after the FIFO samples fifo_rd_en high.
//
// Signals:
//   fifo_data   [7:0]  FIFO data_out (driven by the FIFO)
//   fifo_empty         FIFO empty flag (driven by the FIFO)
//   fifo_rd_en         one-cycle read strobe (driven by the transmitter)
//
// Modports:
//   master  - the transmitter (consumer that issues reads)
//   slave   - the FIFO (supplier of data and empty flag)
// -----------------------------------------------------------------------------
interface uart_tx_fifo_drain_if;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_rd_en;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        output fifo_rd_en
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        input  fifo_rd_en
    );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
//
// UART transmitter placed directly downstream of the transmit FIFO. It pops
// one byte per frame through the FIFO's registered read port and serialises
// it: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop
// bits. The bit-period counter is internal and reloads at every bit boundary.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (4..65535)
//   PARITY        0 = none, 1 = even, 2 = odd
//   STOP_BITS     1 or 2
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         asynchronous, active-low reset
//   fifo        FIFO read port (master side: fifo_data, fifo_empty in,
//               fifo_rd_en out)
//   tx_en       1 = new frames may start; 0 = finish current frame, then idle
//   tx          serial line, idle high
//   busy        high from the read request through the last stop-bit cycle
//   frame_done  one-cycle pulse after the final stop bit completes
//
// All outputs come straight from flops; nothing combinational reaches them.
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_fifo_drain_if.master fifo,
    input  logic                 tx_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       DATA_LAST = 3'd7;
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [7:0]       shift_reg, shift_reg_nx;
    logic             par_bit, par_bit_nx;
    logic             tx_nx;
    logic             busy_nx;
    logic             rd_en_nx;
    logic             frame_done_nx;
    logic             bit_end;

    // Parity over the popped byte; the none case never reaches the line.
    function automatic logic parity_bit(input logic [7:0] b);
        case (PARITY)
            1:       return ^b;
            2:       return ~^b;
            default: return 1'b0;
        endcase
    endfunction

    // The baud counter counts down and reaches zero in the last cycle of
    // every bit, so each bit is held exactly CLKS_PER_BIT cycles.
    assign bit_end = (baud_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            baud_cnt        <= '0;
            bit_idx         <= '0;
            shift_reg       <= '0;
            par_bit         <= 1'b0;
            tx              <= 1'b1;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            fifo.fifo_rd_en <= 1'b0;
        end else begin
            state           <= state_nx;
            baud_cnt        <= baud_cnt_nx;
            bit_idx         <= bit_idx_nx;
            shift_reg       <= shift_reg_nx;
            par_bit         <= par_bit_nx;
            tx              <= tx_nx;
            busy            <= busy_nx;
            frame_done      <= frame_done_nx;
            fifo.fifo_rd_en <= rd_en_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        baud_cnt_nx   = baud_cnt;
        bit_idx_nx    = bit_idx;
        shift_reg_nx  = shift_reg;
        par_bit_nx    = par_bit;
        tx_nx         = tx;
        busy_nx       = busy;
        rd_en_nx      = 1'b0;
        frame_done_nx = 1'b0;

        case (state)
            ST_IDLE: begin
                tx_nx = 1'b1;
                // fifo_empty is only looked at here, so the FIFO's flag lag
                // after a pop can never cause a second read in one frame.
                if (tx_en && !fifo.fifo_empty) begin
                    state_nx = ST_REQ;
                    rd_en_nx = 1'b1;
                    busy_nx  = 1'b1;
                end
            end

            ST_REQ: begin
                // Strobe is high this cycle; the FIFO commits the pop at the
                // closing edge regardless of what its empty flag does now.
                state_nx = ST_LOAD;
            end

            ST_LOAD: begin
                shift_reg_nx = fifo.fifo_data;
                par_bit_nx   = parity_bit(fifo.fifo_data);
                tx_nx        = 1'b0;
                baud_cnt_nx  = BIT_LAST;
                state_nx     = ST_START;
            end

            ST_START: begin
                if (bit_end) begin
                    tx_nx       = shift_reg[0];
                    baud_cnt_nx = BIT_LAST;
                    bit_idx_nx  = '0;
                    state_nx    = ST_DATA;
                end else begin
                    baud_cnt_nx = baud_cnt - CNT_ONE;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_nx = BIT_LAST;
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_nx = '0;
                        if (PARITY != 0) begin
                            tx_nx    = par_bit;
                            state_nx = ST_PARITY;
                        end else begin
                            tx_nx    = 1'b1;
                            state_nx = ST_STOP;
                        end
                    end else begin
                        // shift_reg[0] is the bit on the line; the next one
                        // sits in [1] and moves down as we shift.
                        tx_nx        = shift_reg[1];
                        shift_reg_nx = {1'b0, shift_reg[7:1]};
                        bit_idx_nx   = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt - CNT_ONE;
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    tx_nx       = 1'b1;
                    baud_cnt_nx = BIT_LAST;
                    bit_idx_nx  = '0;
                    state_nx    = ST_STOP;
                end else begin
                    baud_cnt_nx = baud_cnt - CNT_ONE;
                end
            end

            ST_STOP: begin
                tx_nx = 1'b1;
                if (bit_end) begin
                    // bit_idx counts stop bits so two stop bits reuse the
                    // same bit-period counter.
                    if (bit_idx == STOP_LAST) begin
                        busy_nx       = 1'b0;
                        frame_done_nx = 1'b1;
                        state_nx      = ST_IDLE;
                    end else begin
                        bit_idx_nx  = bit_idx + 3'd1;
                        baud_cnt_nx = BIT_LAST;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt - CNT_ONE;
                end
            end

            default: begin
                state_nx = ST_IDLE;
                tx_nx    = 1'b1;
                busy_nx  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
//
// Four transmitters, each fed by its own behavioural 16-entry FIFO with a
// registered read port:
//   0: CLKS_PER_BIT=8, no parity, 1 stop
//   1: CLKS_PER_BIT=8, even parity, 1 stop
//   2: CLKS_PER_BIT=8, odd parity, 1 stop
//   3: CLKS_PER_BIT=4, no parity, 2 stop
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_drain;

    logic clk;
    logic rst;

    logic [3:0]      tx_en;
    logic [3:0]      tx;
    logic [3:0]      busy;
    logic [3:0]      frame_done;
    logic [3:0]      rd_en_mon;
    logic [3:0]      underflow;
    logic [3:0]      push;
    logic [3:0][7:0] pdata;
    logic [3:0][4:0] fcnt;

    int unsigned rdcnt [4];

    int vectors;
    int miscompares;

    logic cap_tx   [0:127];
    logic cap_busy [0:127];
    logic cap_fd   [0:127];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        uart_tx_fifo_drain_if bus ();

        logic [7:0] mem [16];
        logic [3:0] wp;
        logic [3:0] rp;
        logic [4:0] cnt;
        logic [7:0] dout;
        logic       uf;
        logic       pop;

        assign bus.fifo_data  = dout;
        assign bus.fifo_empty = (cnt == 5'd0);
        assign pop            = bus.fifo_rd_en && (cnt != 5'd0);
        assign rd_en_mon[g]   = bus.fifo_rd_en;
        assign fcnt[g]        = cnt;
        assign underflow[g]   = uf;

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                wp   <= '0;
                rp   <= '0;
                cnt  <= '0;
                dout <= '0;
                uf   <= 1'b0;
            end else begin
                if (push[g]) begin
                    mem[wp] <= pdata[g];
                    wp      <= wp + 4'd1;
                end
                if (bus.fifo_rd_en && cnt == 5'd0) uf <= 1'b1;
                if (pop) begin
                    dout <= mem[rp];
                    rp   <= rp + 4'd1;
                end
                case ({push[g], pop})
                    2'b10:   cnt <= cnt + 5'd1;
                    2'b01:   cnt <= cnt - 5'd1;
                    default: cnt <= cnt;
                endcase
            end
        end

        uart_tx_fifo_drain #(
            .CLKS_PER_BIT ((g == 3) ? 4 : 8),
            .PARITY       ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
            .STOP_BITS    ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .fifo       (bus),
            .tx_en      (tx_en[g]),
            .tx         (tx[g]),
            .busy       (busy[g]),
            .frame_done (frame_done[g])
        );
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) rdcnt[i] <= 0;
        end else begin
            for (int i = 0; i < 4; i++) if (rd_en_mon[i]) rdcnt[i] <= rdcnt[i] + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_byte(input int g, input logic [7:0] b);
        push[g]  = 1'b1;
        pdata[g] = b;
        tick();
        push[g]  = 1'b0;
    endtask

    // Returns with n = falling edges waited; on return tx[g] is 0 unless the
    // budget ran out.
    task automatic wait_txfall(input int g, input int maxc, output int n);
        n = 0;
        while (tx[g] !== 1'b0 && n < maxc) begin
            tick();
            n++;
        end
    endtask

    task automatic capture(input int g, input int from, input int n);
        for (int k = from; k < from + n; k++) begin
            cap_tx[k]   = tx[g];
            cap_busy[k] = busy[g];
            cap_fd[k]   = frame_done[g];
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        int bad_tx;
        int bad_rd;
        int bad_busy;
        rst = 1'b0;
        repeat (3) tick();
        vectors++;
        if (tx !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_tx: got %b expected 1111", tx);
        end
        vectors++;
        if (busy !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0000", busy);
        end
        vectors++;
        if (rd_en_mon !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_rd_en: got %b expected 0000", rd_en_mon);
        end
        vectors++;
        if (frame_done !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_frame_done: got %b expected 0000", frame_done);
        end
        rst = 1'b1;
        tick();

        // Start a frame of 0x3C and reset in the middle of data bit 1 (a 0).
        push_byte(0, 8'h3C);
        wait_txfall(0, 20, n);
        vectors++;
        if (tx[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pre_start: got %b expected 0 within 20 cycles", tx[0]);
        end
        repeat (20) tick();
        vectors++;
        if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_data: got tx=%b busy=%b expected tx=0 busy=1", tx[0], busy[0]);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || rd_en_mon[0] !== 1'b0 || frame_done[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_frame: got tx=%b busy=%b rd=%b fd=%b expected 1 0 0 0",
                     tx[0], busy[0], rd_en_mon[0], frame_done[0]);
        end
        tick();
        rst = 1'b1;
        bad_tx = 0;
        bad_rd = 0;
        bad_busy = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (tx[0] !== 1'b1) bad_tx++;
            if (rd_en_mon[0] !== 1'b0) bad_rd++;
            if (busy[0] !== 1'b0) bad_busy++;
        end
        vectors++;
        if (bad_tx != 0) begin
            miscompares++;
            $display("FAIL reset_idle_tx: got %0d low cycles expected 0", bad_tx);
        end
        vectors++;
        if (bad_rd != 0 || bad_busy != 0) begin
            miscompares++;
            $display("FAIL reset_idle_ctrl: got rd=%0d busy=%0d active cycles expected 0 0", bad_rd, bad_busy);
        end
    endtask

    task automatic test_single();
        int n;
        int bad_busy;
        int unsigned s;
        logic [9:0] line;
        line = 10'b1_1010_0101_0;   // stop, 0xA5, start (LSB = start)
        s = rdcnt[0];
        push_byte(0, 8'hA5);
        n = 0;
        while (rd_en_mon[0] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if (rd_en_mon[0] !== 1'b1 || busy[0] !== 1'b1 || tx[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_req: got rd=%b busy=%b tx=%b expected 1 1 1", rd_en_mon[0], busy[0], tx[0]);
        end
        tick();
        vectors++;
        if (rd_en_mon[0] !== 1'b0 || tx[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL single_load: got rd=%b tx=%b expected 0 1", rd_en_mon[0], tx[0]);
        end
        tick();
        vectors++;
        if (tx[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_tx_fall: got %b expected 0 two edges after read", tx[0]);
        end
        capture(0, 0, 84);
        bad_busy = 0;
        for (int k = 0; k < 80; k++) begin
            vectors++;
            if (cap_tx[k] !== line[k / 8]) begin
                miscompares++;
                $display("FAIL single_line[%0d]: got %b expected %b", k, cap_tx[k], line[k / 8]);
            end
            if (cap_busy[k] !== 1'b1) bad_busy++;
        end
        vectors++;
        if (bad_busy != 0 || cap_busy[80] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy: got %0d low-in-frame, busy@80=%b expected 0 and 0", bad_busy, cap_busy[80]);
        end
        vectors++;
        if ({cap_fd[79], cap_fd[80], cap_fd[81]} !== 3'b010) begin
            miscompares++;
            $display("FAIL single_frame_done: got %b%b%b expected 010", cap_fd[79], cap_fd[80], cap_fd[81]);
        end
        vectors++;
        if (rdcnt[0] - s != 1) begin
            miscompares++;
            $display("FAIL single_rd_pulses: got %0d expected 1", rdcnt[0] - s);
        end
    endtask

    task automatic test_parity();
        int n;
        int g;
        logic [7:0]  b;
        logic [10:0] line;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: begin g = 1; b = 8'h07; line = {1'b1, 1'b1, 8'h07, 1'b0}; end
                1: begin g = 2; b = 8'h07; line = {1'b1, 1'b0, 8'h07, 1'b0}; end
                default: begin g = 1; b = 8'hA5; line = {1'b1, 1'b0, 8'hA5, 1'b0}; end
            endcase
            push_byte(g, b);
            wait_txfall(g, 20, n);
            vectors++;
            if (tx[g] !== 1'b0) begin
                miscompares++;
                $display("FAIL parity%0d_start: got %b expected 0 within 20 cycles", c, tx[g]);
            end
            capture(g, 0, 92);
            for (int k = 0; k < 88; k++) begin
                vectors++;
                if (cap_tx[k] !== line[k / 8]) begin
                    miscompares++;
                    $display("FAIL parity%0d_line[%0d]: got %b expected %b", c, k, cap_tx[k], line[k / 8]);
                end
            end
            vectors++;
            if ({cap_busy[87], cap_busy[88], cap_fd[88]} !== 3'b101) begin
                miscompares++;
                $display("FAIL parity%0d_length: got busy87=%b busy88=%b fd88=%b expected 1 0 1",
                         c, cap_busy[87], cap_busy[88], cap_fd[88]);
            end
        end
    endtask

    task automatic test_stop2();
        int n;
        int ones;
        logic [10:0] line;
        line = {2'b11, 8'hFF, 1'b0};
        push_byte(3, 8'hFF);
        n = 0;
        while (rd_en_mon[3] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if (rd_en_mon[3] !== 1'b1 || busy[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL stop2_req: got rd=%b busy=%b expected 1 1", rd_en_mon[3], busy[3]);
        end
        tick();
        tick();
        capture(3, 0, 48);
        for (int k = 0; k < 44; k++) begin
            vectors++;
            if (cap_tx[k] !== line[k / 4]) begin
                miscompares++;
                $display("FAIL stop2_line[%0d]: got %b expected %b", k, cap_tx[k], line[k / 4]);
            end
        end
        ones = 0;
        for (int k = 0; k < 48; k++) if (cap_busy[k] === 1'b1) ones++;
        vectors++;
        if (ones != 44 || cap_busy[44] !== 1'b0) begin
            miscompares++;
            $display("FAIL stop2_busy: got %0d busy cycles from tx fall expected 44", ones);
        end
        vectors++;
        if ({cap_fd[43], cap_fd[44], cap_fd[45]} !== 3'b010) begin
            miscompares++;
            $display("FAIL stop2_frame_done: got %b%b%b expected 010", cap_fd[43], cap_fd[44], cap_fd[45]);
        end
    endtask

    task automatic test_burst();
        int n;
        int unsigned s;
        logic [7:0] got;
        logic [7:0] want;
        tx_en[0] = 1'b0;
        for (int i = 0; i < 16; i++) push_byte(0, 8'(i));
        tick();
        s = rdcnt[0];
        vectors++;
        if (fcnt[0] !== 5'd16 || tx[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL burst_preload: got count=%0d tx=%b expected 16 1", fcnt[0], tx[0]);
        end
        tx_en[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            want = 8'(i);
            wait_txfall(0, 10, n);
            vectors++;
            if (tx[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL burst%0d_start: got %b expected 0 within 10 cycles", i, tx[0]);
            end
            if (i > 0) begin
                vectors++;
                if (n != 3) begin
                    miscompares++;
                    $display("FAIL burst%0d_gap: got %0d idle cycles expected 3", i, n);
                end
            end
            capture(0, 0, 80);
            for (int b = 0; b < 8; b++) got[b] = cap_tx[8 * (b + 1) + 4];
            vectors++;
            if ({cap_tx[76], got, cap_tx[4]} !== {1'b1, want, 1'b0}) begin
                miscompares++;
                $display("FAIL burst%0d_frame: got %b_%h_%b expected 1_%h_0", i, cap_tx[76], got, cap_tx[4], want);
            end
        end
        repeat (40) tick();
        vectors++;
        if (rdcnt[0] - s != 16 || underflow[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_reads: got %0d reads underflow=%b expected 16 0", rdcnt[0] - s, underflow[0]);
        end
        vectors++;
        if (fcnt[0] !== 5'd0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_drained: got count=%0d tx=%b busy=%b expected 0 1 0", fcnt[0], tx[0], busy[0]);
        end
    endtask

    task automatic test_gating();
        int n;
        int bad_tx;
        int unsigned s;
        logic [7:0] got;
        logic [7:0] want;
        s = rdcnt[0];
        tx_en[0] = 1'b1;
        push_byte(0, 8'h41);
        push_byte(0, 8'h42);
        push_byte(0, 8'h43);
        wait_txfall(0, 10, n);
        vectors++;
        if (tx[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_start: got %b expected 0 within 10 cycles", tx[0]);
        end
        capture(0, 0, 36);
        tx_en[0] = 1'b0;          // middle of data bit 3
        capture(0, 36, 46);
        for (int b = 0; b < 8; b++) got[b] = cap_tx[8 * (b + 1) + 4];
        vectors++;
        if (got !== 8'h41 || cap_tx[76] !== 1'b1 || cap_fd[80] !== 1'b1) begin
            miscompares++;
            $display("FAIL gate_frame1: got byte=%h stop=%b fd=%b expected 41 1 1", got, cap_tx[76], cap_fd[80]);
        end
        bad_tx = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (tx[0] !== 1'b1) bad_tx++;
        end
        vectors++;
        if (bad_tx != 0 || rdcnt[0] - s != 1 || fcnt[0] !== 5'd2) begin
            miscompares++;
            $display("FAIL gate_hold: got low=%0d reads=%0d count=%0d expected 0 1 2", bad_tx, rdcnt[0] - s, fcnt[0]);
        end
        tx_en[0] = 1'b1;
        for (int f = 0; f < 2; f++) begin
            want = (f == 0) ? 8'h42 : 8'h43;
            wait_txfall(0, 10, n);
            vectors++;
            if (tx[0] !== 1'b0 || n > 3) begin
                miscompares++;
                $display("FAIL gate_resume%0d: got tx=%b after %0d cycles expected 0 within 3", f, tx[0], n);
            end
            capture(0, 0, 80);
            for (int b = 0; b < 8; b++) got[b] = cap_tx[8 * (b + 1) + 4];
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL gate_byte%0d: got %h expected %h", f, got, want);
            end
        end
        repeat (10) tick();
        vectors++;
        if (rdcnt[0] - s != 3 || fcnt[0] !== 5'd0) begin
            miscompares++;
            $display("FAIL gate_total: got reads=%0d count=%0d expected 3 0", rdcnt[0] - s, fcnt[0]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        tx_en       = 4'hF;
        push        = 4'h0;
        pdata       = '0;
        test_reset();
        test_single();
        test_parity();
        test_stop2();
        test_burst();
        test_gating();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

endmodule
